// File: rtl/core_lsu.sv
// core_lsu: byte/half/word loads and stores onto a word-aligned data bus; CORE_LSU_TIMEOUT_EN adds an ack timeout.
// Latency: DONE two cycles after REQ with a zero-wait MEM_ACK; rejected accesses report DONE+ERR one cycle after REQ.
// Backpressure: REQ is ignored while BUSY; the bus request is held stable until MEM_ACK (or timeout).
module core_lsu #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ,
   input  logic        WE,
   input  logic [2:0]  FUNCT3,
   input  logic [31:0] ADDR,
   input  logic [31:0] WDATA,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR,
   output logic [31:0] RDATA,
   output logic        MEM_REQ,
   output logic        MEM_WE,
   output logic [31:0] MEM_ADDR,
   output logic [3:0]  MEM_BE,
   output logic [31:0] MEM_WDATA,
   input  logic        MEM_ACK,
   input  logic [31:0] MEM_RDATA
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t      state, state_nxt;
   logic        we_q, err_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic        legal, misal, in_access, accept, req_ok, req_bad, tmo_hit;
   logic [31:0] ld_shift, ld_ext, wd_lanes;
   logic [3:0]  be_w;

   always_comb begin
      legal = 1'b0;
      misal = 1'b0;
      case (FUNCT3)
         3'd0, 3'd1, 3'd2: legal = 1'b1;
         3'd4, 3'd5:       legal = !WE;
         default:          legal = 1'b0;
      endcase
      case (FUNCT3)
         3'd1, 3'd5: misal = ADDR[0];
         3'd2:       misal = |ADDR[1:0];
         default:    misal = 1'b0;
      endcase
   end

   assign in_access = (state == ACCESS);
   assign accept    = REQ && !in_access;
   assign req_ok    = accept && legal && !misal;
   assign req_bad   = accept && !(legal && !misal);

`ifdef CORE_LSU_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] tmo_cnt;

   always_ff @(posedge CLK) begin
      if (RST)
         tmo_cnt <= '0;
      else if (req_ok)
         tmo_cnt <= '0;
      else if (in_access && !MEM_ACK)
         tmo_cnt <= tmo_cnt + CNT_W'(1);
   end

   // An ack arriving in the expiry cycle still completes normally.
   assign tmo_hit = in_access && !MEM_ACK && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic tmo_unused;
   assign tmo_unused = (TIMEOUT_CYCLES != 0);
   assign tmo_hit    = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         ACCESS: if (MEM_ACK || tmo_hit) state_nxt = RESP;
         default: begin
            if (req_ok)       state_nxt = ACCESS;
            else if (req_bad) state_nxt = RESP;
            else              state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      ld_shift = MEM_RDATA >> {addr_q[1:0], 3'b000};
      ld_ext   = ld_shift;
      case (funct3_q)
         3'd0:    ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'd1:    ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
         3'd4:    ld_ext = {24'b0, ld_shift[7:0]};
         3'd5:    ld_ext = {16'b0, ld_shift[15:0]};
         default: ld_ext = ld_shift;
      endcase
      be_w     = 4'b1111;
      wd_lanes = wdata_q;
      case (funct3_q[1:0])
         2'd0: begin
            be_w     = 4'b0001 << addr_q[1:0];
            wd_lanes = {4{wdata_q[7:0]}};
         end
         2'd1: begin
            be_w     = 4'b0011 << {addr_q[1], 1'b0};
            wd_lanes = {2{wdata_q[15:0]}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (req_ok) begin
            we_q     <= WE;
            funct3_q <= FUNCT3;
            addr_q   <= ADDR;
            wdata_q  <= WDATA;
         end
         if (req_bad) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
         end else if (in_access && MEM_ACK) begin
            err_q   <= 1'b0;
            rdata_q <= we_q ? '0 : ld_ext;
         end else if (tmo_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
         end
      end
   end

   assign BUSY      = in_access;
   assign DONE      = (state == RESP);
   assign ERR       = DONE && err_q;
   assign RDATA     = rdata_q;
   assign MEM_REQ   = in_access;
   assign MEM_WE    = in_access && we_q;
   assign MEM_ADDR  = in_access ? {addr_q[31:2], 2'b00} : '0;
   assign MEM_BE    = in_access ? be_w : '0;
   assign MEM_WDATA = in_access ? wd_lanes : '0;

endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: directed and randomized accesses against a transaction-level model of the load/store unit.
// Latency: the model predicts every output on every cycle; outputs are compared on the falling edge.
// Backpressure: REQ noise is injected while BUSY and MEM_ACK noise outside ACCESS; both must be ignored.
module tb_core_lsu;

   localparam int TMO = 4;

   logic        CLK = 1'b0;
   logic        RST, REQ, WE, MEM_ACK;
   logic [2:0]  FUNCT3;
   logic [31:0] ADDR, WDATA, MEM_RDATA;
   logic        BUSY, DONE, ERR, MEM_REQ, MEM_WE;
   logic [31:0] RDATA, MEM_ADDR, MEM_WDATA;
   logic [3:0]  MEM_BE;

   core_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
      .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE), .FUNCT3(FUNCT3), .ADDR(ADDR), .WDATA(WDATA),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA),
      .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE),
      .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
   );

   always #5 CLK = ~CLK;

   int          n_pass = 0;
   int          n_total = 0;
   bit          chk_en = 1'b0;
   logic        e_busy, e_done, e_err, e_mreq, e_mwe;
   logic [31:0] e_rdata, e_maddr, e_mwd;
   logic [3:0]  e_be;
   logic [31:0] m_rdata;
   logic [3:0]  last_be;
   logic [31:0] last_wd, last_addr;
   logic        last_we;
   int          req_cycles;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Access size in bytes; f3[1:0]==3 only occurs for illegal codes.
   function automatic int sz(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit bad_acc(input logic we, input logic [2:0] f3, input logic [31:0] a);
      bit legal;
      legal = (f3 <= 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
      return !legal || ((int'(a[1:0]) % sz(f3)) != 0);
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] lo);
      logic [3:0] be;
      be = 4'b0;
      for (int b = 0; b < 4; b++)
         if (b >= int'(lo) && b < int'(lo) + sz(f3)) be[b] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] o;
      o = '0;
      for (int b = 0; b < 4; b++) o[8*b +: 8] = wd[8*(b % sz(f3)) +: 8];
      return o;
   endfunction

   function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] rd);
      int s;
      logic [31:0] v, mask;
      s    = sz(f3);
      v    = rd >> (8 * int'(lo));
      mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
      v    = v & mask;
      if (!f3[2] && s < 4 && v[8*s-1]) v = v | ~mask;
      return v;
   endfunction

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("BUSY",      {31'b0, BUSY},    {31'b0, e_busy});
         chk("DONE",      {31'b0, DONE},    {31'b0, e_done});
         chk("ERR",       {31'b0, ERR},     {31'b0, e_err});
         chk("RDATA",     RDATA,            e_rdata);
         chk("MEM_REQ",   {31'b0, MEM_REQ}, {31'b0, e_mreq});
         chk("MEM_WE",    {31'b0, MEM_WE},  {31'b0, e_mwe});
         chk("MEM_ADDR",  MEM_ADDR,         e_maddr);
         chk("MEM_BE",    {28'b0, MEM_BE},  {28'b0, e_be});
         chk("MEM_WDATA", MEM_WDATA,        e_mwd);
         if (MEM_REQ === 1'b1) begin
            req_cycles++;
            last_be   = MEM_BE;
            last_wd   = MEM_WDATA;
            last_addr = MEM_ADDR;
            last_we   = MEM_WE;
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_idle_exp();
      e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_mreq = 1'b0; e_mwe = 1'b0;
      e_maddr = '0; e_be = 4'b0; e_mwd = '0; e_rdata = m_rdata;
   endtask

   task automatic set_access_exp(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      set_idle_exp();
      e_busy = 1'b1; e_mreq = 1'b1; e_mwe = we;
      e_maddr = {a[31:2], 2'b00}; e_be = m_be(f3, a[1:0]); e_mwd = m_wd(f3, wd);
   endtask

   task automatic drive_noise(input bit req_noise);
      REQ = req_noise ? 1'($urandom) : 1'b0;
      WE = 1'($urandom); FUNCT3 = 3'($urandom); ADDR = $urandom; WDATA = $urandom;
      MEM_ACK = req_noise ? 1'b0 : 1'($urandom);
      MEM_RDATA = $urandom;
   endtask

   task automatic idle();
      drive_noise(1'b0);
      step();
      set_idle_exp();
   endtask

   // Issues one access from a non-busy cycle and returns in its DONE cycle.
   task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input int delay, input logic [31:0] rdv, input bit noisy);
      logic [31:0] rd;
      bit to;
      to = 1'b0;
      rd = '0;
      REQ = 1'b1; WE = we; FUNCT3 = f3; ADDR = a; WDATA = wd;
      MEM_ACK = 1'($urandom); MEM_RDATA = $urandom;
      req_cycles = 0;
      step();
      if (bad_acc(we, f3, a)) begin
         m_rdata = '0;
         set_idle_exp();
         e_done = 1'b1; e_err = 1'b1;
      end else begin
         for (int i = 0; i <= delay; i++) begin
            set_access_exp(we, f3, a, wd);
            drive_noise(noisy);
            rd = (i == delay) ? rdv : $urandom;
            MEM_RDATA = rd;
            MEM_ACK = (i == delay);
            step();
            if (i == delay) break;
`ifdef CORE_LSU_TIMEOUT_EN
            if (i == TMO - 1) begin
               to = 1'b1;
               break;
            end
`endif
         end
         m_rdata = (we || to) ? 32'h0 : m_ld(f3, a[1:0], rd);
         set_idle_exp();
         e_done = 1'b1; e_err = to;
      end
      drive_noise(1'b0);
   endtask

   initial begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_a;

      RST = 1'b1;
      drive_noise(1'b0);
      m_rdata = '0;
      req_cycles = 0;
      step();
      step();
      set_idle_exp();
      chk_en = 1'b1;
      chk("reset_busy", {31'b0, BUSY}, 32'd0);
      chk("reset_mem_req", {31'b0, MEM_REQ}, 32'd0);
      RST = 1'b0;
      idle();

      // LW with zero-wait ack
      xact(1'b0, 3'd2, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
      chk("lw_done", {31'b0, DONE}, 32'd1);
      chk("lw_err", {31'b0, ERR}, 32'd0);
      chk("lw_rdata", RDATA, 32'hDEAD_BEEF);
      chk("lw_addr", last_addr, 32'h100);
      chk("lw_be", {28'b0, last_be}, 32'hF);
      chk("lw_req_cycles", req_cycles, 32'd1);
      idle();

      // LB / LBU of the top byte
      xact(1'b0, 3'd0, 32'h103, 32'h0, 0, 32'h8011_2233, 1'b0);
      chk("lb_rdata", RDATA, 32'hFFFF_FF80);
      chk("lb_be", {28'b0, last_be}, 32'h8);
      idle();
      xact(1'b0, 3'd4, 32'h103, 32'h0, 0, 32'h8011_2233, 1'b0);
      chk("lbu_rdata", RDATA, 32'h0000_0080);
      idle();
      idle();
      chk("rdata_hold", RDATA, 32'h0000_0080);

      // SH upper half with a 3-cycle ack delay
      xact(1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 3, 32'h0, 1'b1);
      chk("sh_we", {31'b0, last_we}, 32'd1);
      chk("sh_addr", last_addr, 32'h200);
      chk("sh_be", {28'b0, last_be}, 32'hC);
      chk("sh_wdata", last_wd, 32'hABCD_ABCD);
      chk("sh_req_cycles", req_cycles, 32'd4);
      chk("sh_rdata", RDATA, 32'h0);
      idle();

      // Misaligned LW then illegal store back to back
      xact(1'b0, 3'd2, 32'h101, 32'h0, 0, 32'h0, 1'b0);
      chk("misal_err", {31'b0, ERR}, 32'd1);
      chk("misal_req_cycles", req_cycles, 32'd0);
      xact(1'b1, 3'd3, 32'h100, 32'h0, 0, 32'h0, 1'b0);
      chk("illegal_err", {31'b0, ERR}, 32'd1);
      chk("illegal_done", {31'b0, DONE}, 32'd1);
      chk("illegal_req_cycles", req_cycles, 32'd0);
      idle();

      // REQ during ACCESS is ignored, then reset abandons the access
      req_cycles = 0;
      REQ = 1'b1; WE = 1'b0; FUNCT3 = 3'd2; ADDR = 32'h300; WDATA = 32'h0; MEM_ACK = 1'b0;
      step();
      set_access_exp(1'b0, 3'd2, 32'h300, 32'h0);
      REQ = 1'b1; WE = 1'b1; FUNCT3 = 3'd0; ADDR = 32'h404; WDATA = 32'h55; MEM_ACK = 1'b0;
      step();
      set_access_exp(1'b0, 3'd2, 32'h300, 32'h0);
      REQ = 1'b0; RST = 1'b1; MEM_ACK = 1'b0;
      step();
      m_rdata = '0;
      set_idle_exp();
      RST = 1'b0;
      drive_noise(1'b0);
      step();
      set_idle_exp();
      chk("rst_mem_req", {31'b0, MEM_REQ}, 32'd0);
      chk("rst_busy", {31'b0, BUSY}, 32'd0);
      chk("rst_no_done", {31'b0, DONE}, 32'd0);
      chk("rst_ignored_req", last_addr, 32'h300);
      chk("rst_req_cycles", req_cycles, 32'd2);
      idle();

      // Ack withheld for a long time
      xact(1'b0, 3'd2, 32'h500, 32'h0, 20, 32'h1357_9BDF, 1'b1);
`ifdef CORE_LSU_TIMEOUT_EN
      chk("tmo_err", {31'b0, ERR}, 32'd1);
      chk("tmo_rdata", RDATA, 32'h0);
      chk("tmo_req_cycles", req_cycles, 32'd4);
`else
      chk("notmo_err", {31'b0, ERR}, 32'd0);
      chk("notmo_rdata", RDATA, 32'h1357_9BDF);
      chk("notmo_req_cycles", req_cycles, 32'd21);
`endif
      idle();

      for (int t = 0; t < 300; t++) begin
         r_we = 1'($urandom);
         r_f3 = 3'($urandom_range(0, 7));
         r_a  = $urandom;
         if ($urandom_range(0, 1) == 1) r_a[1:0] = 2'b00;
         xact(r_we, r_f3, r_a, $urandom, $urandom_range(0, 5), $urandom, 1'b1);
         if ($urandom_range(0, 1) == 1)
            repeat ($urandom_range(1, 2)) idle();
      end
      idle();
      idle();
      chk_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
